// File: rtl/wlm_pkg.sv
// Shared types and helpers for the wlm reduction unit and its arbiter.
//   wlm_lat()  : pipeline latency of wlm for a given set of FF_* stage enables
//   wlm_tag_t  : in-flight tag {valid, id}; id is sized for up to 16 requesters
package wlm_pkg;

  localparam int TAG_IDW = 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } wlm_tag_t;

  function automatic int wlm_lat(input int ff_in, input int ff_sub, input int ff_mul,
                                 input int ff_sum, input int ff_out);
    return ff_in + ff_sub + ff_mul + ff_sum + ff_out;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted index and wraps.
// Every grant is an accept (grant only where req is set), so the pointer moves
// on any grant and holds otherwise.
//   clk, rst : clock, async active-high reset (pointer -> N-1, so 0 wins first)
//   req      : request vector         grant     : one-hot or zero
//   grant_id : index of the grant     grant_any : some grant this cycle
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_any
);
  logic [IDW-1:0] last_q, last_d;

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N);
  endfunction

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!grant_any && req[nxt(last_q, k)]) begin
        grant_any              = 1'b1;
        grant[nxt(last_q, k)]  = 1'b1;
        grant_id               = nxt(last_q, k);
      end
    end
    last_d = grant_any ? grant_id : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDW'(N-1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/wlm.sv
// Pipelined word-level Montgomery reduction for q = qH*2^W + 1, W = LOGQ-LOGQH.
// Because q == 1 mod 2^W, the Montgomery factor is simply m = -C mod 2^W and
// T = (C + m*q) / 2^W, optionally corrected once by q. T == C * 2^-W mod q.
// Each FF_* enables a register after the named step; pipeline regs are not reset.
//   clk : clock           C  : 2*LOGQ operand
//   qH  : modulus high part  T : LOGQ reduced result, LAT cycles after C/qH
module wlm import wlm_pkg::*; #(
  parameter int LOGQ    = 64,
  parameter int LOGQH   = 32,
  parameter int CORRECT = 1,
  parameter int FF_IN   = 1,
  parameter int FF_SUB  = 1,
  parameter int FF_MUL  = 1,
  parameter int FF_SUM  = 1,
  parameter int FF_OUT  = 1,
  parameter int EXP_LAT = 5
) (
  input  logic                clk,
  input  logic [2*LOGQ-1:0]   C,
  input  logic [LOGQH-1:0]    qH,
  output logic [LOGQ-1:0]     T
);
  localparam int W   = LOGQ - LOGQH;
  localparam int SW  = 2*LOGQ + 1;
  localparam int TW  = SW - W;
  localparam int LAT = wlm_lat(FF_IN, FF_SUB, FF_MUL, FF_SUM, FF_OUT);

  // The arbiter sizes its tag pipeline from its own latency calculation.
  if (LAT != EXP_LAT) begin : g_lat_chk
    $error("wlm latency does not match the caller's expectation");
  end

  logic [2*LOGQ-1:0] c0, c1, c2;
  logic [LOGQH-1:0]  qh0;
  logic [W-1:0]      m_d, m1;
  logic [LOGQ-1:0]   q_d, q1, q2, q3;
  logic [W+LOGQ-1:0] mq_d, mq2;
  logic [SW-1:0]     sum;
  logic [TW-1:0]     t_d, t3, tc;
  logic [LOGQ-1:0]   t_out;

  if (FF_IN != 0) begin : g_ff_in
    always_ff @(posedge clk) begin c0 <= C; qh0 <= qH; end
  end else begin : g_nff_in
    always_comb begin c0 = C; qh0 = qH; end
  end

  assign m_d = {W{1'b0}} - c0[W-1:0];
  assign q_d = {qh0, {W{1'b0}}} | LOGQ'(1);
  if (FF_SUB != 0) begin : g_ff_sub
    always_ff @(posedge clk) begin m1 <= m_d; q1 <= q_d; c1 <= c0; end
  end else begin : g_nff_sub
    always_comb begin m1 = m_d; q1 = q_d; c1 = c0; end
  end

  assign mq_d = (W+LOGQ)'(m1) * (W+LOGQ)'(q1);
  if (FF_MUL != 0) begin : g_ff_mul
    always_ff @(posedge clk) begin mq2 <= mq_d; q2 <= q1; c2 <= c1; end
  end else begin : g_nff_mul
    always_comb begin mq2 = mq_d; q2 = q1; c2 = c1; end
  end

  // Low W bits of the sum are zero by construction of m.
  assign sum = SW'(c2) + SW'(mq2);
  assign t_d = sum[SW-1:W];
  if (FF_SUM != 0) begin : g_ff_sum
    always_ff @(posedge clk) begin t3 <= t_d; q3 <= q2; end
  end else begin : g_nff_sum
    always_comb begin t3 = t_d; q3 = q2; end
  end

  assign tc    = (CORRECT != 0 && t3 >= TW'(q3)) ? t3 - TW'(q3) : t3;
  assign t_out = LOGQ'(tc);
  if (FF_OUT != 0) begin : g_ff_out
    always_ff @(posedge clk) T <= t_out;
  end else begin : g_nff_out
    always_comb T = t_out;
  end

endmodule

// File: rtl/wlm_arbiter.sv
// Shares one pipelined wlm among NREQ requesters. One accept per cycle via a
// round-robin grant; a {valid,id} tag pipeline of wlm latency follows each
// operation so the registered response carries its requester index.
//   clk, rst              : clock, async active-high reset
//   req_valid/req_ready   : per-requester handshake (ready is the grant)
//   req_C / req_qH        : packed per-requester operands
//   resp_valid/id/T       : registered result, no backpressure
//   busy                  : work in flight or response pending
// Optional WLM_ARB_STATS_EN: stat_issued (per-requester accepts) and stat_idle
// (cycles without accept), both 32-bit saturating.
module wlm_arbiter import wlm_pkg::*; #(
  parameter int LOGQ    = 64,
  parameter int LOGQH   = 32,
  parameter int CORRECT = 1,
  parameter int FF_IN   = 1,
  parameter int FF_SUB  = 1,
  parameter int FF_MUL  = 1,
  parameter int FF_SUM  = 1,
  parameter int FF_OUT  = 1,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][2*LOGQ-1:0]      req_C,
  input  logic [NREQ-1:0][LOGQH-1:0]       req_qH,
  output logic                             resp_valid,
  output logic [IDW-1:0]                   resp_id,
  output logic [LOGQ-1:0]                  resp_T,
  output logic                             busy
`ifdef WLM_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][31:0]            stat_issued,
  output logic [31:0]                      stat_idle
`endif
);
  localparam int LAT = wlm_lat(FF_IN, FF_SUB, FF_MUL, FF_SUM, FF_OUT);

  if (NREQ < 2 || NREQ > 16) begin : g_nreq_chk
    $error("NREQ must be in 2..16");
  end
  if (LAT < 1) begin : g_lat_chk
    $error("wlm must have at least one pipeline stage");
  end

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_id;
  logic              grant_any;
  logic [2*LOGQ-1:0] wlm_c;
  logic [LOGQH-1:0]  wlm_qh;
  logic [LOGQ-1:0]   wlm_t;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
    .clk(clk), .rst(rst), .req(req_valid),
    .grant(grant), .grant_id(grant_id), .grant_any(grant_any)
  );
  assign req_ready = grant;

  // Idle cycles feed zeros so the unit's datapath stays quiet.
  always_comb begin
    wlm_c  = '0;
    wlm_qh = '0;
    if (grant_any) begin
      wlm_c  = req_C[grant_id];
      wlm_qh = req_qH[grant_id];
    end
  end

  wlm #(
    .LOGQ(LOGQ), .LOGQH(LOGQH), .CORRECT(CORRECT),
    .FF_IN(FF_IN), .FF_SUB(FF_SUB), .FF_MUL(FF_MUL), .FF_SUM(FF_SUM), .FF_OUT(FF_OUT),
    .EXP_LAT(LAT)
  ) wlm_inst (.clk(clk), .C(wlm_c), .qH(wlm_qh), .T(wlm_t));

  wlm_tag_t        tag_q [LAT];
  wlm_tag_t        tag_d [LAT];
  wlm_tag_t        tail;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [LOGQ-1:0] resp_T_q, resp_T_d;

  assign tail = tag_q[LAT-1];

  // Tail of the tag pipeline lines up with the wlm output of the same op.
  always_comb begin
    tag_d[0].valid = grant_any;
    tag_d[0].id    = TAG_IDW'(grant_id);
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
    resp_valid_d = tail.valid;
    resp_id_d    = resp_id_q;
    resp_T_d     = resp_T_q;
    if (tail.valid) begin
      resp_id_d = IDW'(tail.id);
      resp_T_d  = wlm_t;
    end
  end

  // Clearing the tags is what drops in-flight work on reset; the wlm
  // registers keep stale data but it is never tagged valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_T_q     <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_T_q     <= resp_T_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_T     = resp_T_q;

  always_comb begin
    busy = resp_valid_q;
    for (int i = 0; i < LAT; i++) busy = busy | tag_q[i].valid;
  end

`ifdef WLM_ARB_STATS_EN
  logic [NREQ-1:0][31:0] issued_q, issued_d;
  logic [31:0]           idle_q, idle_d;

  always_comb begin
    issued_d = issued_q;
    idle_d   = idle_q;
    for (int i = 0; i < NREQ; i++)
      if (grant[i] && issued_q[i] != '1) issued_d[i] = issued_q[i] + 32'd1;
    if (!grant_any && idle_q != '1) idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      idle_q   <= '0;
    end else begin
      issued_q <= issued_d;
      idle_q   <= idle_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_idle   = idle_q;
`endif

endmodule

// File: tb/tb_wlm_arbiter.sv
// Directed bench for wlm_arbiter (NREQ=4, all FF_*=1, latency 5).
module tb_wlm_arbiter;
  localparam int NREQ = 4;
  localparam int LOGQ = 64;
  localparam int LOGQH = 32;
  localparam int L = 5;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ-1:0][2*LOGQ-1:0] req_C;
  logic [NREQ-1:0][LOGQH-1:0] req_qH;
  logic resp_valid;
  logic [1:0] resp_id;
  logic [LOGQ-1:0] resp_T;
  logic busy;
`ifdef WLM_ARB_STATS_EN
  logic [NREQ-1:0][31:0] stat_issued;
  logic [31:0] stat_idle;
`endif

  wlm_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_C(req_C), .req_qH(req_qH), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_T(resp_T), .busy(busy)
`ifdef WLM_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_idle(stat_idle)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] c; logic [31:0] qh; logic [63:0] t; } vec_t;
  typedef struct { logic [3:0] v; logic [3:0] rdy; int vi; } row_t;
  typedef struct { int id; logic [63:0] t; int due; } exp_t;

  vec_t vecs [NV];
  row_t rows [$];
  exp_t sbq [$];
  exp_t e;
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Response scoreboard: each accept is due exactly L+1 cycles later.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        chk("resp_missed", 64'(cyc), 64'(e.due));
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_T", resp_T, e.t);
      end else begin
        chk("resp_idle", 64'(resp_valid), 64'd0);
      end
    end
  end

  // One cycle: drive at posedge+#1, check grant at negedge, log accept.
  task automatic do_row(input logic [3:0] v, input logic [3:0] rdy, input int vi);
    exp_t x;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_C[i]  = vecs[(vi + i) % NV].c;
      req_qH[i] = vecs[(vi + i) % NV].qh;
    end
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (rdy[i]) begin
        x.id = i; x.t = vecs[(vi + i) % NV].t; x.due = cyc + L + 1;
        sbq.push_back(x);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // q = qH*2^32+1; T = C*2^-32 mod q, hand-derived.
    vecs[0] = '{128'h7_0000_0000, 32'd1, 64'h7};
    vecs[1] = '{128'h1, 32'd1, 64'h1_0000_0000};
    vecs[2] = '{128'h1_0000_0006_0000_0000, 32'd1, 64'h5};
    vecs[3] = '{128'h1234_5678_0000_0000, 32'd1, 64'h1234_5678};
    vecs[4] = '{128'h0, 32'd1, 64'h0};
    vecs[5] = '{128'h9_0000_0000, 32'd3, 64'h9};
    vecs[6] = '{128'h2, 32'd1, 64'hFFFF_FFFF};
    vecs[7] = '{128'h1_0000_0000_0000_0000, 32'd1, 64'h1_0000_0000};
    vecs[8] = '{128'h3_0000_0003_0000_0000, 32'd3, 64'h2};
    vecs[9] = '{128'h1, 32'd3, 64'h2_FFFF_FFFE};

    // Single requester 2, then drain.
    rows.push_back('{4'b0100, 4'b0100, 0});
    for (int i = 0; i < 7; i++) rows.push_back('{4'b0000, 4'b0000, 0});
    // Requester 3 alone moves the pointer to 3, then all four for 8 cycles.
    rows.push_back('{4'b1000, 4'b1000, 1});
    for (int i = 0; i < 8; i++) rows.push_back('{4'b1111, 4'b0001 << (i % 4), i});
    // Requesters 1 and 3 alternate; an idle slot mid-stream.
    rows.push_back('{4'b1010, 4'b0010, 2});
    rows.push_back('{4'b1010, 4'b1000, 3});
    rows.push_back('{4'b1010, 4'b0010, 4});
    rows.push_back('{4'b0000, 4'b0000, 0});
    rows.push_back('{4'b1010, 4'b1000, 5});
    rows.push_back('{4'b1010, 4'b0010, 6});
    // Pointer wrap cases.
    rows.push_back('{4'b0001, 4'b0001, 7});
    rows.push_back('{4'b0110, 4'b0010, 8});
    rows.push_back('{4'b0101, 4'b0100, 9});
    rows.push_back('{4'b0101, 4'b0001, 1});
    rows.push_back('{4'b1001, 4'b1000, 2});
    for (int i = 0; i < L + 3; i++) rows.push_back('{4'b0000, 4'b0000, 0});

    rst = 1'b1; req_valid = '0; req_C = '0; req_qH = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_T", resp_T, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_none", 64'(req_ready), 64'd0);
    req_valid = 4'b1111; #1;
    chk("rst_ready_all", 64'(req_ready), 64'b0001);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (rows[r]) do_row(rows[r].v, rows[r].rdy, rows[r].vi);

    // busy spans the pipeline and the response cycle, then falls.
    do_row(4'b0100, 4'b0100, 3);
    for (int j = 1; j <= 7; j++) begin
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("busy_%0d", j), 64'(busy), 64'(j <= L + 1));
      @(posedge clk); #1;
    end

    // Reset with three operations in flight.
    do_row(4'b0111, 4'b0001, 4);
    do_row(4'b0111, 4'b0010, 5);
    do_row(4'b0111, 4'b0100, 6);
    rst = 1'b1; sbq.delete(); req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    for (int j = 0; j < 2 * L; j++) do_row(4'b0000, 4'b0000, 0);
    do_row(4'b1000, 4'b1000, 7);
    for (int j = 0; j < L + 3; j++) do_row(4'b0000, 4'b0000, 0);

`ifdef WLM_ARB_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 10; j++) do_row(4'b0001, 4'b0001, j);
    for (int j = 0; j < 5; j++) do_row(4'b0000, 4'b0000, 0);
    chk("stat_issued0", 64'(stat_issued[0]), 64'd10);
    chk("stat_issued1", 64'(stat_issued[1]), 64'd0);
    chk("stat_issued2", 64'(stat_issued[2]), 64'd0);
    chk("stat_issued3", 64'(stat_issued[3]), 64'd0);
    chk("stat_idle", 64'(stat_idle), 64'd5);
    for (int j = 0; j < L + 3; j++) do_row(4'b0000, 4'b0000, 0);
`endif

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
